// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling, feeding a small byte FIFO.
// Sticky frame/overrun flags; one byte per cycle can be drained from the head.
module uart_rx_fifo #(
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rstn,
    input  logic                     rxd,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     frame_err,
    output logic                     overrun,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    logic [1:0]    sync_q, sync_d;
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [DEPTH];

    logic rxs_s;
    logic tick_s;
    logic push_s;
    logic frame_set_s;
    logic pop_s;
    logic full_s;
    logic wr_en_s;
    logic ovr_set_s;

    assign rxs_s  = sync_q[1];
    assign tick_s = (div_q == DW'(DIV - 1));
    assign sync_d = {sync_q[0], rxd};

    // Receiver FSM: every sample point is a tick edge with a given tick count.
    always_comb begin
        state_d     = state_q;
        div_d       = tick_s ? {DW{1'b0}} : div_q + DW'(1);
        tick_cnt_d  = tick_s ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d      = {DW{1'b0}};
                tick_cnt_d = 4'd0;
                bit_cnt_d  = 3'd0;
                if (!rxs_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s && (tick_cnt_q == 4'd7)) begin
                    tick_cnt_d = 4'd0;
                    if (rxs_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                // Tick counter wraps 15 -> 0, so each wrap is the next mid-bit.
                if (tick_s && (tick_cnt_q == 4'd15)) begin
                    shift_d   = {rxs_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (tick_s && (tick_cnt_q == 4'd15)) begin
                    if (rxs_s) begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set_s = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a same-cycle pop frees the slot a full-FIFO push needs.
    always_comb begin
        pop_s     = (count_q != CW'(0)) && rx_ready;
        full_s    = (count_q == CW'(DEPTH));
        wr_en_s   = push_s && (!full_s || pop_s);
        ovr_set_s = push_s && full_s && !pop_s;
        wr_ptr_d  = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (frame_set_s) begin
            frame_err_d = 1'b1;
        end else if (err_clr) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            div_q       <= {DW{1'b0}};
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            div_q       <= div_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage array; contents need no reset since count gates validity.
    always_ff @(posedge sys_clk) begin
        if (sys_rstn && wr_en_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_data   = mem_q[rd_ptr_q];
    assign rx_valid  = (count_q != CW'(0));
    assign rx_count  = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 frames at 64 cycles/bit, inline checks per scenario.
module tb_uart_rx_fifo;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int BITC  = 16 * DIV;

    logic       sys_clk = 1'b0;
    logic       sys_rstn = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [7:0] popq [$];

    uart_rx_fifo #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rstn  (sys_rstn),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // Log every byte handed over by a pop handshake.
    always @(posedge sys_clk) begin
        if (sys_rstn && rx_valid && rx_ready) popq.push_back(rx_data);
    end

    // Drives one frame; i counts negedges, the next posedge carries frame bit i/BITC.
    task automatic send_frame(input logic [7:0] b, input int ready_at, input int clr_at, input int rst_at);
        logic [9:0] fr;
        int bi;
        fr  = {1'b1, b, 1'b0};
        rxd = 1'b0;
        for (int i = 1; i <= 10 * BITC; i++) begin
            @(negedge sys_clk);
            bi  = i / BITC;
            rxd = (bi < 10) ? fr[bi] : 1'b1;
            if (ready_at != 0) rx_ready = (i == ready_at);
            if (clr_at != 0) err_clr = (i == clr_at);
            if (rst_at != 0) sys_rstn = (i != rst_at);
        end
    endtask

    task automatic test_reset();
        sys_rstn = 1'b0;
        rxd = 1'b1;
        repeat (15) @(negedge sys_clk);
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (rx_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", rx_count); else pass_cnt++;
        chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun); else pass_cnt++;
        sys_rstn = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_single_byte();
        logic [9:0] fr;
        int bi;
        popq.delete();
        fr  = {1'b1, 8'hA5, 1'b0};
        rxd = 1'b0;
        // First low posedge is P+1, T0 = P+3, stop sample/push at P+611.
        for (int i = 1; i <= 10 * BITC; i++) begin
            @(negedge sys_clk);
            if (i == 610) begin
                chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", rx_valid); else pass_cnt++;
            end
            if (i == 611) begin
                chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rx_valid); else pass_cnt++;
                chk_cnt++; if (rx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", rx_data); else pass_cnt++;
                chk_cnt++; if (rx_count !== 3'd1) $display("FAIL single_count: got %0d want 1", rx_count); else pass_cnt++;
                chk_cnt++; if ({frame_err, overrun} !== 2'b00) $display("FAIL single_flags: got %b want 00", {frame_err, overrun}); else pass_cnt++;
            end
            bi  = i / BITC;
            rxd = (bi < 10) ? fr[bi] : 1'b1;
        end
        rx_ready = 1'b1;
        @(negedge sys_clk);
        rx_ready = 1'b0;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL single_pop_valid: got %b want 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (popq.size() !== 1) $display("FAIL single_pop_n: got %0d want 1", popq.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        popq.delete();
        rx_ready = 1'b1;
        for (int k = 1; k <= 6; k++) send_frame(8'(k), 0, 0, 0);
        repeat (4) @(negedge sys_clk);
        rx_ready = 1'b0;
        chk_cnt++; if (popq.size() !== 6) $display("FAIL b2b_pops: got %0d want 6", popq.size()); else pass_cnt++;
        for (int k = 1; k <= 6; k++) begin
            got = (popq.size() >= k) ? popq[k-1] : 8'hxx;
            chk_cnt++; if (got !== 8'(k)) $display("FAIL b2b_byte%0d: got %h want %h", k, got, 8'(k)); else pass_cnt++;
        end
        chk_cnt++; if ({frame_err, overrun} !== 2'b00) $display("FAIL b2b_flags: got %b want 00", {frame_err, overrun}); else pass_cnt++;
        chk_cnt++; if (rx_count !== 3'd0) $display("FAIL b2b_count: got %0d want 0", rx_count); else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [7:0] exp_q [5];
        logic [7:0] got;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
        popq.delete();
        rx_ready = 1'b0;
        send_frame(8'h11, 0, 0, 0);
        send_frame(8'h22, 0, 0, 0);
        send_frame(8'h33, 0, 0, 0);
        send_frame(8'h44, 0, 0, 0);
        // err_clr coincides with the overrun-setting push: set wins.
        send_frame(8'h55, 0, 610, 0);
        chk_cnt++; if (rx_count !== 3'd4) $display("FAIL ovr_count: got %0d want 4", rx_count); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'h11) $display("FAIL ovr_head: got %h want 11", rx_data); else pass_cnt++;
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clr: got %b want 0", overrun); else pass_cnt++;
        send_frame(8'h66, 610, 0, 0);
        chk_cnt++; if (rx_count !== 3'd4) $display("FAIL ovr_pushpop_count: got %0d want 4", rx_count); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_pushpop_flag: got %b want 0", overrun); else pass_cnt++;
        rx_ready = 1'b1;
        repeat (4) @(negedge sys_clk);
        rx_ready = 1'b0;
        chk_cnt++; if (rx_count !== 3'd0) $display("FAIL ovr_drain_count: got %0d want 0", rx_count); else pass_cnt++;
        chk_cnt++; if (popq.size() !== 5) $display("FAIL ovr_drain_n: got %0d want 5", popq.size()); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            got = (popq.size() > k) ? popq[k] : 8'hxx;
            chk_cnt++; if (got !== exp_q[k]) $display("FAIL ovr_drain%0d: got %h want %h", k, got, exp_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_frame_break();
        popq.delete();
        sys_rstn = 1'b0;
        rxd = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rstn = 1'b1;
        repeat (1000) @(negedge sys_clk);
        chk_cnt++; if (frame_err !== 1'b1) $display("FAIL brk_ferr: got %b want 1", frame_err); else pass_cnt++;
        chk_cnt++; if (rx_count !== 3'd0) $display("FAIL brk_count: got %0d want 0", rx_count); else pass_cnt++;
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        repeat (1000) @(negedge sys_clk);
        chk_cnt++; if (frame_err !== 1'b0) $display("FAIL brk_once: got %b want 0", frame_err); else pass_cnt++;
        rxd = 1'b1;
        repeat (20) @(negedge sys_clk);
        send_frame(8'h3C, 0, 0, 0);
        chk_cnt++; if (rx_data !== 8'h3C || rx_valid !== 1'b1) $display("FAIL brk_rx: got %h/%b want 3c/1", rx_data, rx_valid); else pass_cnt++;
        rx_ready = 1'b1;
        @(negedge sys_clk);
        rx_ready = 1'b0;
        chk_cnt++; if (rx_count !== 3'd0) $display("FAIL brk_pop: got %0d want 0", rx_count); else pass_cnt++;
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (16) @(negedge sys_clk);
        rxd = 1'b1;
        repeat (100) @(negedge sys_clk);
        chk_cnt++; if (rx_count !== 3'd0) $display("FAIL glitch_count: got %0d want 0", rx_count); else pass_cnt++;
        chk_cnt++; if ({frame_err, overrun} !== 2'b00) $display("FAIL glitch_flags: got %b want 00", {frame_err, overrun}); else pass_cnt++;
        send_frame(8'h7E, 0, 0, 0);
        chk_cnt++; if (rx_data !== 8'h7E || rx_count !== 3'd1) $display("FAIL glitch_rx: got %h/%0d want 7e/1", rx_data, rx_count); else pass_cnt++;
        rx_ready = 1'b1;
        @(negedge sys_clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        popq.delete();
        send_frame(8'h5A, 0, 0, 0);
        chk_cnt++; if (rx_count !== 3'd1) $display("FAIL mid_pre_count: got %0d want 1", rx_count); else pass_cnt++;
        // Reset pulse lands inside data bit 4; remaining bits of 0xF5 are all high.
        send_frame(8'hF5, 0, 0, 340);
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (rx_count !== 3'd0) $display("FAIL mid_count: got %0d want 0", rx_count); else pass_cnt++;
        chk_cnt++; if ({frame_err, overrun} !== 2'b00) $display("FAIL mid_flags: got %b want 00", {frame_err, overrun}); else pass_cnt++;
        send_frame(8'h96, 0, 0, 0);
        chk_cnt++; if (rx_data !== 8'h96 || rx_count !== 3'd1) $display("FAIL mid_rx: got %h/%0d want 96/1", rx_data, rx_count); else pass_cnt++;
        rx_ready = 1'b1;
        @(negedge sys_clk);
        rx_ready = 1'b0;
        chk_cnt++; if (popq.size() !== 1) $display("FAIL mid_pops: got %0d want 1", popq.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_frame_break();
        test_glitch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the microSystem UART channel: takes the raw `UART_RxD0` pin, synchronises and oversamples it, deframes 8N1 characters and buffers them in a small FIFO. The UART bus-slave register file pops bytes from it. It sits directly upstream of the CPU's UART data/status registers.

## Interface
- `DIV`, default 4: `sys_clk` cycles per oversample tick; one bit time is 16·DIV cycles. The default is for simulation.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, ≥2.
- `sys_clk` input, 1 bit: the single clock. All state updates on its rising edge.
- `sys_rstn` input, 1 bit: reset, synchronous and active-low.
- `rxd` input, 1 bit: asynchronous serial line. Idle level is 1.
- `rx_data` output, 8 bits: the byte at the FIFO head. Valid only while `rx_valid` is 1.
- `rx_valid` output, 1 bit: the FIFO is not empty.
- `rx_ready` input, 1 bit: consumer accepts the head byte. A pop happens in a cycle where `rx_valid` and `rx_ready` are both 1.
- `rx_count` output, log2(DEPTH)+1 bits: current FIFO occupancy.
- `frame_err` output, 1 bit: sticky flag. A stop bit was sampled as 0.
- `overrun` output, 1 bit: sticky flag. A byte was received while the FIFO was full and no pop occurred that cycle.
- `err_clr` input, 1 bit: one-cycle pulse that clears both sticky flags.

## Operation
- **Synchroniser:** a 2-flop synchroniser on `rxd`, both flops reset to 1. `rxs` is the synchronised value.
- **Receiver state machine:** states IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: if `rxs`=0, go to START. The divider and the 4-bit tick counter clear in that same cycle, called T0.
  - START: at tick 8 (mid start bit), if `rxs`=1 the edge was a glitch and the state returns to IDLE with no flag change. Otherwise go to DATA, and the tick counter restarts.
  - DATA: sample `rxs` at every 16th tick, which is the mid-bit point. Bits shift in LSB first. After bit 7, go to STOP.
  - STOP: sample at mid stop bit.
    - If 1: push the byte and go to IDLE. Returning at mid stop bit allows back-to-back frames.
    - If 0: discard the byte, set `frame_err`, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. A line held low (break, or a disconnected pin) therefore produces exactly one framing error.
- **FIFO:** circular buffer with DEPTH entries.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is tracked separately.
  - `rx_data` is driven combinationally from `mem[rd_ptr]`.
  - Push while not full: write the byte and increment the count.
  - Push while full with no pop in the same cycle: drop the byte, set `overrun`, leave the FIFO contents unchanged.
  - Push while full with a pop in the same cycle: both take effect, the count is unchanged, and `overrun` is not set.
  - Push and pop together while not full: both take effect, and the count is unchanged.
  - Pop while empty: ignored.
- **Sticky flags:** a set event takes priority over `err_clr` in the same cycle, so the flag stays 1.
- **Reset:** reset mid-frame abandons the frame. The receiver returns to IDLE and no partial byte is pushed.

## Timing
- **Reset values:** `rx_valid`=0, `rx_count`=0, `frame_err`=0, `overrun`=0. Pointers are 0, the state is IDLE, and the synchroniser holds 11. `rx_data` is don't-care while `rx_valid` is 0.
- **T0:** T0 is 2 cycles after the first rising edge at which the pin is seen low (synchroniser delay).
- **Sample points, relative to T0:**
  - Start-bit check at T0 + 8·DIV.
  - Data bit k sampled at T0 + (24+16k)·DIV.
  - Stop bit sampled at T0 + 152·DIV.
- **Push latency:** the FIFO write happens on the clock edge of the stop sample. `rx_valid` and the new `rx_count` are visible the following cycle.
- **Pop:** takes effect at the edge where `rx_valid`·`rx_ready`=1. The next byte, or `rx_valid`=0, is visible the next cycle, so one byte per cycle can be drained.
- **Flags:** `frame_err` and `overrun` assert the cycle after their triggering edge. `err_clr` takes effect at its edge.
- **Baud tolerance:** the receiver tolerates ±3% baud mismatch, because sampling is at mid-bit.

## Test plan
- **Single byte:** DIV=4. Reset low for 15 cycles with `rxd`=1, then send 0xA5 as 8N1 at 64 cycles/bit. Required: `rx_valid` rises at T0+609, `rx_data`=0xA5, `rx_count`=1, no flags set. Pulse `rx_ready` for one cycle; `rx_valid` then drops the next cycle.
- **Back-to-back and wrap:** send 0x01 through 0x06 with no idle gap between frames, and hold `rx_ready`=1 throughout. Required: six pops, in order 0x01..0x06, with pointers wrapping past DEPTH. `overrun`=0 and `frame_err`=0.
- **Overrun and simultaneous push/pop:**
  - Send 5 bytes with `rx_ready`=0. Required: `rx_count`=4, `overrun`=1, and the FIFO holds bytes 1–4.
  - Pulse `err_clr`, then assert `rx_ready` on the exact cycle of the 6th push. Required: count stays at 4, `overrun` stays 0.
- **Framing error and break:**
  - Release reset with `rxd`=0 and hold it low for 2000 cycles. Required: `frame_err`=1 exactly once, nothing pushed.
  - Raise `rxd`, then send 0x3C. Required: 0x3C is received.
  - Pulse `err_clr`. Required: `frame_err`=0.
- **Glitch rejection:** drive a 16-cycle low pulse on `rxd` (shorter than 8·DIV). Required: the state returns to IDLE, no push, no flags. A valid 0x7E sent afterwards is received correctly.
- **Reset mid-frame:** assert `sys_rstn`=0 for one cycle during data bit 4 of a frame. Required: all outputs return to their reset values, and no byte appears from the abandoned frame. A subsequent frame is received correctly.
